// File: rtl/rv32_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// The BTB is built only when RV32_BRANCH_PREDICTOR_EN is defined; otherwise static predict-not-taken.
module rv32_branch_predictor #(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_in,
   output logic        predicted_taken_out,
   output logic [31:0] predicted_pc_out,
   input  logic        update_valid_in,
   input  logic [31:0] update_pc_in,
   input  logic        update_taken_in,
   input  logic [31:0] update_target_in
);

   logic [31:0] next_pc_s;

   // Fall-through PC; 32-bit add wraps naturally at the top of the address space.
   always_comb begin
      next_pc_s = pc_in + 32'd4;
   end

`ifdef RV32_BRANCH_PREDICTOR_EN

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 32 - IDX - 2;

   logic [ENTRIES-1:0] valid_r;
   logic [TAGW-1:0]    tag_r    [ENTRIES];
   logic [31:0]        target_r [ENTRIES];
   logic [1:0]         ctr_r    [ENTRIES];

   logic [IDX-1:0]  look_idx_s;
   logic [TAGW-1:0] look_tag_s;
   logic            look_hit_s;
   logic [IDX-1:0]  upd_idx_s;
   logic [TAGW-1:0] upd_tag_s;
   logic            upd_hit_s;
   logic            unused_s;

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
      logic [1:0] res;
      if (up) begin
         res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
      end
      return res;
   endfunction

   assign unused_s = ^update_pc_in[1:0];

   // Combinational lookup; a same-cycle update is not bypassed.
   always_comb begin
      look_idx_s          = pc_in[IDX+1:2];
      look_tag_s          = pc_in[31:IDX+2];
      look_hit_s          = 1'b0;
      predicted_taken_out = 1'b0;
      predicted_pc_out    = next_pc_s;
      if (valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s)) begin
         look_hit_s = 1'b1;
      end else begin
         look_hit_s = 1'b0;
      end
      if (look_hit_s && ctr_r[look_idx_s][1]) begin
         predicted_taken_out = 1'b1;
         predicted_pc_out    = target_r[look_idx_s];
      end else begin
         predicted_taken_out = 1'b0;
         predicted_pc_out    = next_pc_s;
      end
   end

   // Decode the update port's index and tag match.
   always_comb begin
      upd_idx_s = update_pc_in[IDX+1:2];
      upd_tag_s = update_pc_in[31:IDX+2];
      if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
         upd_hit_s = 1'b1;
      end else begin
         upd_hit_s = 1'b0;
      end
   end

   // Valid bits and counters: train on hit, allocate weak-taken on taken miss.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_r[i] <= 2'b00;
         end
      end else if (update_valid_in) begin
         if (upd_hit_s) begin
            ctr_r[upd_idx_s] <= sat_ctr(ctr_r[upd_idx_s], update_taken_in);
         end else if (update_taken_in) begin
            valid_r[upd_idx_s] <= 1'b1;
            ctr_r[upd_idx_s]   <= 2'b10;
         end
      end
   end

   // Tag/target payload needs no reset: it is qualified by valid_r. Rewriting the tag on a hit is a no-op.
   always_ff @(posedge clk) begin
      if (update_valid_in && update_taken_in) begin
         tag_r[upd_idx_s]    <= upd_tag_s;
         target_r[upd_idx_s] <= update_target_in;
      end
   end

`else

   logic unused_s;

   assign unused_s = ^{clk, reset_n, update_valid_in, update_pc_in, update_taken_in,
                       update_target_in, 32'(ENTRIES)};

   // Static predict-not-taken.
   always_comb begin
      predicted_taken_out = 1'b0;
      predicted_pc_out    = next_pc_s;
   end

`endif

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Scoreboard bench for rv32_branch_predictor; expectations adapt to RV32_BRANCH_PREDICTOR_EN.
module tb_rv32_branch_predictor;

`ifdef RV32_BRANCH_PREDICTOR_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [31:0] pc_in;
   logic        predicted_taken_out;
   logic [31:0] predicted_pc_out;
   logic        update_valid_in;
   logic [31:0] update_pc_in;
   logic        update_taken_in;
   logic [31:0] update_target_in;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   rv32_branch_predictor #(.ENTRIES(64)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .pc_in               (pc_in),
      .predicted_taken_out (predicted_taken_out),
      .predicted_pc_out    (predicted_pc_out),
      .update_valid_in     (update_valid_in),
      .update_pc_in        (update_pc_in),
      .update_taken_in     (update_taken_in),
      .update_target_in    (update_target_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive pc_in, queue expectation, then pop and compare once settled (low clock phase).
   task automatic lookup(input string name, input logic [31:0] pc,
                         input logic exp_taken, input logic [31:0] exp_pc);
      exp_t e;
      exp_t got;
      pc_in = pc;
      e.name = name; e.taken = exp_taken; e.pc = exp_pc;
      exp_q.push_back(e);
      #1;
      got = exp_q.pop_front();
      checks++;
      if (predicted_taken_out !== got.taken || predicted_pc_out !== got.pc) begin
         failures++;
         $display("FAIL %s: got taken=%0b pc=%08h expected taken=%0b pc=%08h",
                  got.name, predicted_taken_out, predicted_pc_out, got.taken, got.pc);
      end
   endtask

   // Expected value for a predicted-taken hit; collapses to fall-through when the BTB is absent.
   function automatic logic [31:0] hit_pc(input logic [31:0] pc, input logic [31:0] tgt);
      return EN ? tgt : pc + 32'd4;
   endfunction

   task automatic set_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      update_valid_in  = 1'b1;
      update_pc_in     = pc;
      update_taken_in  = taken;
      update_target_in = tgt;
   endtask

   // One update applied at the next rising edge; returns on the following falling edge.
   task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      set_update(pc, taken, tgt);
      @(posedge clk);
      @(negedge clk);
      update_valid_in = 1'b0;
   endtask

   task automatic do_reset();
      update_valid_in = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      lookup("reset_pc0",    32'h0000_0000, 1'b0, 32'h0000_0004);
      lookup("reset_pc100",  32'h0000_0100, 1'b0, 32'h0000_0104);
      lookup("reset_pcwrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
   endtask

   task automatic test_alloc();
      set_update(32'h0000_0100, 1'b1, 32'h0000_0200);
      lookup("alloc_same_cycle", 32'h0000_0100, 1'b0, 32'h0000_0104);
      @(posedge clk);
      @(negedge clk);
      update_valid_in = 1'b0;
      lookup("alloc_next_cycle", 32'h0000_0100, EN, hit_pc(32'h0000_0100, 32'h0000_0200));
      lookup("alloc_other_pc",   32'h0000_0104, 1'b0, 32'h0000_0108);
   endtask

   task automatic test_saturation();
      do_reset();
      do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
      lookup("sat_alloc_10", 32'h0000_0100, EN, hit_pc(32'h0000_0100, 32'h0000_0200));
      do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
      lookup("sat_up_11", 32'h0000_0100, EN, hit_pc(32'h0000_0100, 32'h0000_0200));
      do_update(32'h0000_0100, 1'b0, 32'h0000_0000);
      lookup("sat_dn_10", 32'h0000_0100, EN, hit_pc(32'h0000_0100, 32'h0000_0200));
      do_update(32'h0000_0100, 1'b0, 32'h0000_0000);
      lookup("sat_dn_01", 32'h0000_0100, 1'b0, 32'h0000_0104);
      do_update(32'h0000_0100, 1'b0, 32'h0000_0000);
      lookup("sat_dn_00", 32'h0000_0100, 1'b0, 32'h0000_0104);
      do_update(32'h0000_0100, 1'b0, 32'h0000_0000);
      lookup("sat_floor_00", 32'h0000_0100, 1'b0, 32'h0000_0104);
      // From 00 one taken gives 01 (still not-taken); a wrap to 11 would predict taken here.
      do_update(32'h0000_0100, 1'b1, 32'h0000_0240);
      lookup("sat_up_01", 32'h0000_0100, 1'b0, 32'h0000_0104);
      do_update(32'h0000_0100, 1'b1, 32'h0000_0280);
      lookup("sat_up_10_newtgt", 32'h0000_0100, EN, hit_pc(32'h0000_0100, 32'h0000_0280));
   endtask

   task automatic test_alias();
      do_reset();
      do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
      do_update(32'h0000_1100, 1'b1, 32'h0000_0300);
      lookup("alias_old_miss", 32'h0000_0100, 1'b0, 32'h0000_0104);
      lookup("alias_new_hit",  32'h0000_1100, EN, hit_pc(32'h0000_1100, 32'h0000_0300));
      do_update(32'h0000_2100, 1'b0, 32'h0000_0000);
      lookup("alias_nt_miss_keep", 32'h0000_1100, EN, hit_pc(32'h0000_1100, 32'h0000_0300));
      lookup("alias_nt_no_alloc",  32'h0000_2100, 1'b0, 32'h0000_2104);
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_update(32'h0000_0180, 1'b1, 32'h0000_0500);
      do_update(32'h0000_0180, 1'b0, 32'h0000_0000);
      do_update(32'h0000_0180, 1'b0, 32'h0000_0000);
      lookup("b2b_at_00", 32'h0000_0180, 1'b0, 32'h0000_0184);
      set_update(32'h0000_0180, 1'b1, 32'h0000_0600);
      @(posedge clk);
      @(negedge clk);
      set_update(32'h0000_0180, 1'b1, 32'h0000_0600);
      @(posedge clk);
      @(negedge clk);
      update_valid_in = 1'b0;
      lookup("b2b_00_to_10", 32'h0000_0180, EN, hit_pc(32'h0000_0180, 32'h0000_0600));
   endtask

   task automatic test_reset_discard();
      do_reset();
      do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
      set_update(32'h0000_0300, 1'b1, 32'h0000_0400);
      #2;
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      update_valid_in = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      lookup("rst_discard_pending", 32'h0000_0300, 1'b0, 32'h0000_0304);
      lookup("rst_clears_old",      32'h0000_0100, 1'b0, 32'h0000_0104);
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset_n          = 1'b0;
      pc_in            = 32'h0000_0000;
      update_valid_in  = 1'b0;
      update_pc_in     = 32'h0000_0000;
      update_taken_in  = 1'b0;
      update_target_in = 32'h0000_0000;
      @(negedge clk);
      test_reset();
      test_alloc();
      test_saturation();
      test_alias();
      test_back_to_back();
      test_reset_discard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32_branch_predictor.md
# rv32_branch_predictor

Fetch-stage branch predictor: the prediction end of the branch-resolution path. For each fetch PC it supplies the predicted-taken flag and next PC. These travel down the pipeline to the branch unit, which compares its resolved outcome against them and flags mispredictions. Resolved outcomes return through the update port to train a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.

## Interface
- `ENTRIES`, default 64: number of BTB entries; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pc_in` input 32: fetch PC being looked up; word-aligned.
- `predicted_taken_out` output 1: prediction for `pc_in`; carried down the pipeline as the branch unit's predicted-taken input.
- `predicted_pc_out` output 32: next fetch PC.
- `update_valid_in` input 1: a branch or jump resolved this cycle.
- `update_pc_in` input 32: PC of the resolved instruction.
- `update_taken_in` input 1: resolved direction.
- `update_target_in` input 32: resolved target, bit 0 already cleared.

## Operation
- Per entry: `valid` (1 bit), `tag` (32-IDX-2 bits), `target` (32 bits), `ctr` (2 bits).
- Encoding of `ctr`: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Index is `pc[IDX+1:2]`. Tag is `pc[31:IDX+2]`. `pc[1:0]` is ignored.
- Lookup is purely combinational from `pc_in` and the stored array.
  - Hit = `valid[idx] && tag[idx] == pc_in tag`.
  - If hit and `ctr[1]` = 1: `predicted_taken_out` = 1, `predicted_pc_out` = `target[idx]`.
  - Otherwise: `predicted_taken_out` = 0, `predicted_pc_out` = `pc_in + 4`, computed mod 2^32 so 0xFFFFFFFC wraps to 0x00000000.
- Update applies only when `update_valid_in` = 1, at the clock edge.
  - Tag hit: `ctr` saturates up if taken, down if not taken; it never wraps. If taken, `target` is overwritten with `update_target_in`.
  - Tag miss (including invalid entry) and taken: allocate the entry. Set `valid` = 1, write the tag, `target` = `update_target_in`, `ctr` = 10. Any aliasing entry is overwritten.
  - Tag miss and not taken: no state change; not-taken branches are never allocated.
- No replacement policy beyond direct mapping. No partial updates.

## Timing
- Lookup latency is zero: outputs settle in the same cycle as `pc_in`.
- Update latency is one cycle: a lookup in cycle N observes updates from cycles ≤N-1.
- Lookup and update in the same cycle, same index: the lookup returns the pre-update value. There is no bypass.
- Back-to-back updates to the same entry accumulate, e.g. two taken updates from 00 give 10.
- Reset asynchronously clears all `valid` bits and sets all `ctr` to 00. Tags and targets need no reset.
- After reset: `predicted_taken_out` = 0 and `predicted_pc_out` = `pc_in + 4` for every PC.
- An update pending when `reset_n` falls is discarded.

## Configuration
- `RV32_BRANCH_PREDICTOR_EN` defined: behaviour as above.
- `RV32_BRANCH_PREDICTOR_EN` undefined:
  - No BTB storage is instantiated.
  - `predicted_taken_out` is constant 0; `predicted_pc_out` = `pc_in + 4`.
  - Update inputs are ignored.
  - This is static predict-not-taken: every taken branch is reported mispredicted downstream.

## Test plan
- Reset, then sweep `pc_in` over 0x0, 0x100, 0xFFFFFFFC -> taken = 0; pc_out = 0x4, 0x104, 0x0.
- Update pc 0x100, taken, target 0x200 -> next cycle lookup 0x100 gives taken = 1, pc = 0x200. Lookup in the update cycle itself gives taken = 0, pc = 0x104.
- Counter saturation at pc 0x100: allocate, one more taken, then not-taken ×3 -> counter 11, 10, 01, 00. Prediction 1, 1, 0, 0 after each respective update. A fourth not-taken leaves the counter at 00.
- Aliasing (ENTRIES = 64): allocate 0x100 -> 0x200, then taken update 0x1100 -> 0x300. Lookup 0x100 misses (taken = 0, pc = 0x104); lookup 0x1100 gives 0x300. A not-taken update to a missing pc 0x2100 leaves 0x1100's entry intact.
- Assert `reset_n` mid-stream with `update_valid_in` = 1 -> that update is lost; all lookups return not-taken, pc + 4.
- Build without `RV32_BRANCH_PREDICTOR_EN`, repeat the second scenario -> lookup 0x100 gives taken = 0, pc = 0x104.
